addsub_res_station: RTL and testbench

ADDSUB_RES_STATION -- requirements
Module: addsub_res_station

---
 rtl/addsub_res_station.sv | 264 ++++++++++++++++++++++++++
 tb/tb_addsub_res_station.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_res_station.sv
// addsub_res_station: two-entry reservation station feeding a single add/sub unit.
//
// Instructions are issued with operand values or producer tags (tag 0 = value
// present). Waiting entries snoop the common data bus; a ready entry is dispatched
// to the unit and held there until fu_done, after which the entry is released.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   iss_valid/iss_ready      issue handshake (ready = at least one free entry)
//   iss_op/dest/label        opcode (000 ADD, 001 SUB), destination, owning tag
//   iss_vj/vk, iss_qj/qk     operand values and producer tags
//   cdb_valid/label/data     result broadcast snooped by waiting entries
//   fu_run/op/y/z/dest/label registered command to the add/sub unit
//   fu_done                  unit completion
//   iss_err                  one-cycle pulse on an illegal opcode
//   busy_cnt                 number of occupied entries
//
// Configuration macro: ADDSUB_RS_OLDEST_FIRST_EN -- when defined, dispatch picks
// the oldest ready entry using one age bit per entry; otherwise the lowest index.

module addsub_res_station #(
  parameter int unsigned DW = 9,
  parameter int unsigned TW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [2:0]    iss_op,
  input  logic [2:0]    iss_dest,
  input  logic [TW-1:0] iss_label,
  input  logic [DW-1:0] iss_vj,
  input  logic [DW-1:0] iss_vk,
  input  logic [TW-1:0] iss_qj,
  input  logic [TW-1:0] iss_qk,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_label,
  input  logic [DW-1:0] cdb_data,
  output logic          fu_run,
  output logic [2:0]    fu_op,
  output logic [DW-1:0] fu_y,
  output logic [DW-1:0] fu_z,
  output logic [2:0]    fu_dest,
  output logic [TW-1:0] fu_label,
  input  logic          fu_done,
  output logic          iss_err,
  output logic [1:0]    busy_cnt
);

  localparam int unsigned NE = 2;

  typedef enum logic [1:0] {StFree, StWait, StReady, StExec} ent_st_e;
  typedef enum logic {StIdle, StBusy} disp_st_e;

  ent_st_e       st_q    [NE];
  ent_st_e       st_d    [NE];
  logic [2:0]    op_q    [NE];
  logic [2:0]    op_d    [NE];
  logic [2:0]    dest_q  [NE];
  logic [2:0]    dest_d  [NE];
  logic [TW-1:0] label_q [NE];
  logic [TW-1:0] label_d [NE];
  logic [TW-1:0] qj_q    [NE];
  logic [TW-1:0] qj_d    [NE];
  logic [TW-1:0] qk_q    [NE];
  logic [TW-1:0] qk_d    [NE];
  logic [DW-1:0] vj_q    [NE];
  logic [DW-1:0] vj_d    [NE];
  logic [DW-1:0] vk_q    [NE];
  logic [DW-1:0] vk_d    [NE];

  disp_st_e      disp_q, disp_d;
  logic          xi_q, xi_d;  // index of the executing entry
  logic          fu_run_q, fu_run_d;
  logic [2:0]    fu_op_q, fu_op_d;
  logic [DW-1:0] fu_y_q, fu_y_d;
  logic [DW-1:0] fu_z_q, fu_z_d;
  logic [2:0]    fu_dest_q, fu_dest_d;
  logic [TW-1:0] fu_label_q, fu_label_d;
  logic          err_q, err_d;
  logic [1:0]    cnt_q, cnt_d;

`ifdef ADDSUB_RS_OLDEST_FIRST_EN
  // old_q[i] set: entry i was allocated before the other occupied entry.
  logic          old_q [NE];
  logic          old_d [NE];
`endif

  logic legal, alloc, hit, rdy0, rdy1, sel, ai;

  assign iss_ready = (st_q[0] == StFree) || (st_q[1] == StFree);

  always_comb begin
    for (int i = 0; i < NE; i++) begin
      st_d[i]    = st_q[i];
      op_d[i]    = op_q[i];
      dest_d[i]  = dest_q[i];
      label_d[i] = label_q[i];
      qj_d[i]    = qj_q[i];
      qk_d[i]    = qk_q[i];
      vj_d[i]    = vj_q[i];
      vk_d[i]    = vk_q[i];
`ifdef ADDSUB_RS_OLDEST_FIRST_EN
      old_d[i]   = old_q[i];
`endif
    end
    disp_d     = disp_q;
    xi_d       = xi_q;
    fu_run_d   = fu_run_q;
    fu_op_d    = fu_op_q;
    fu_y_d     = fu_y_q;
    fu_z_d     = fu_z_q;
    fu_dest_d  = fu_dest_q;
    fu_label_d = fu_label_q;

    legal = (iss_op == 3'b000) || (iss_op == 3'b001);
    alloc = iss_valid && iss_ready && legal;
    err_d = iss_valid && iss_ready && !legal;
    // Tag 0 means "no dependency", so a broadcast on label 0 matches nothing.
    hit   = cdb_valid && (cdb_label != '0);

    // Snoop the bus for waiting entries; both operands may resolve together.
    for (int i = 0; i < NE; i++) begin
      if (st_q[i] == StWait) begin
        if (hit && (qj_q[i] == cdb_label)) begin
          vj_d[i] = cdb_data;
          qj_d[i] = '0;
        end
        if (hit && (qk_q[i] == cdb_label)) begin
          vk_d[i] = cdb_data;
          qk_d[i] = '0;
        end
        if ((qj_d[i] == '0) && (qk_d[i] == '0)) begin
          st_d[i] = StReady;
        end
      end
    end

    // Dispatch selection works on registered readiness only.
    rdy0 = (st_q[0] == StReady);
    rdy1 = (st_q[1] == StReady);
`ifdef ADDSUB_RS_OLDEST_FIRST_EN
    sel  = (rdy0 && rdy1) ? old_q[1] : rdy1;
`else
    sel  = !rdy0;
`endif

    if (disp_q == StIdle) begin
      if (rdy0 || rdy1) begin
        st_d[sel]  = StExec;
        disp_d     = StBusy;
        xi_d       = sel;
        fu_run_d   = 1'b1;
        fu_op_d    = op_q[sel];
        fu_y_d     = vj_q[sel];
        fu_z_d     = vk_q[sel];
        fu_dest_d  = dest_q[sel];
        fu_label_d = label_q[sel];
      end
    end else if (fu_done) begin
      st_d[xi_q] = StFree;
`ifdef ADDSUB_RS_OLDEST_FIRST_EN
      old_d[xi_q] = 1'b0;
`endif
      disp_d     = StIdle;
      fu_run_d   = 1'b0;
      fu_op_d    = '0;
      fu_y_d     = '0;
      fu_z_d     = '0;
      fu_dest_d  = '0;
      fu_label_d = '0;
    end

    // Allocation uses registered free state, so an entry freed this edge is not reused.
    ai = (st_q[0] != StFree);
    if (alloc) begin
      op_d[ai]    = iss_op;
      dest_d[ai]  = iss_dest;
      label_d[ai] = iss_label;
      vj_d[ai]    = iss_vj;
      qj_d[ai]    = iss_qj;
      vk_d[ai]    = iss_vk;
      qk_d[ai]    = iss_qk;
      // Bypass a broadcast that coincides with issue so it is never missed.
      if (hit && (iss_qj == cdb_label)) begin
        vj_d[ai] = cdb_data;
        qj_d[ai] = '0;
      end
      if (hit && (iss_qk == cdb_label)) begin
        vk_d[ai] = cdb_data;
        qk_d[ai] = '0;
      end
      st_d[ai] = ((qj_d[ai] == '0) && (qk_d[ai] == '0)) ? StReady : StWait;
`ifdef ADDSUB_RS_OLDEST_FIRST_EN
      old_d[ai]  = 1'b0;
      old_d[!ai] = (st_d[!ai] != StFree);
`endif
    end

    cnt_d = {1'b0, st_d[0] != StFree} + {1'b0, st_d[1] != StFree};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NE; i++) begin
        st_q[i]    <= StFree;
        op_q[i]    <= '0;
        dest_q[i]  <= '0;
        label_q[i] <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
`ifdef ADDSUB_RS_OLDEST_FIRST_EN
        old_q[i]   <= 1'b0;
`endif
      end
      disp_q     <= StIdle;
      xi_q       <= 1'b0;
      fu_run_q   <= 1'b0;
      fu_op_q    <= '0;
      fu_y_q     <= '0;
      fu_z_q     <= '0;
      fu_dest_q  <= '0;
      fu_label_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        st_q[i]    <= st_d[i];
        op_q[i]    <= op_d[i];
        dest_q[i]  <= dest_d[i];
        label_q[i] <= label_d[i];
        qj_q[i]    <= qj_d[i];
        qk_q[i]    <= qk_d[i];
        vj_q[i]    <= vj_d[i];
        vk_q[i]    <= vk_d[i];
`ifdef ADDSUB_RS_OLDEST_FIRST_EN
        old_q[i]   <= old_d[i];
`endif
      end
      disp_q     <= disp_d;
      xi_q       <= xi_d;
      fu_run_q   <= fu_run_d;
      fu_op_q    <= fu_op_d;
      fu_y_q     <= fu_y_d;
      fu_z_q     <= fu_z_d;
      fu_dest_q  <= fu_dest_d;
      fu_label_q <= fu_label_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fu_run   = fu_run_q;
  assign fu_op    = fu_op_q;
  assign fu_y     = fu_y_q;
  assign fu_z     = fu_z_q;
  assign fu_dest  = fu_dest_q;
  assign fu_label = fu_label_q;
  assign iss_err  = err_q;
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_addsub_res_station.sv
// Bench for addsub_res_station: directed vector table, randomized traffic checked
// against a behavioural model, and a reset-during-execution sequence.

module tb_addsub_res_station;

  localparam int unsigned DW = 9;
  localparam int unsigned TW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          iss_valid;
  logic          iss_ready;
  logic [2:0]    iss_op;
  logic [2:0]    iss_dest;
  logic [TW-1:0] iss_label;
  logic [DW-1:0] iss_vj, iss_vk;
  logic [TW-1:0] iss_qj, iss_qk;
  logic          cdb_valid;
  logic [TW-1:0] cdb_label;
  logic [DW-1:0] cdb_data;
  logic          fu_run;
  logic [2:0]    fu_op;
  logic [DW-1:0] fu_y, fu_z;
  logic [2:0]    fu_dest;
  logic [TW-1:0] fu_label;
  logic          fu_done;
  logic          iss_err;
  logic [1:0]    busy_cnt;

  int n_vec = 0;
  int n_bad = 0;

  addsub_res_station #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_dest(iss_dest),
    .iss_label(iss_label), .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj(iss_qj),
    .iss_qk(iss_qk), .cdb_valid(cdb_valid), .cdb_label(cdb_label), .cdb_data(cdb_data),
    .fu_run(fu_run), .fu_op(fu_op), .fu_y(fu_y), .fu_z(fu_z), .fu_dest(fu_dest),
    .fu_label(fu_label), .fu_done(fu_done), .iss_err(iss_err), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: a slot is either empty or holds an instruction; readiness
  // is derived from its tags, age from an allocation sequence number.
  typedef struct {
    bit            used;
    bit            exec;
    logic [2:0]    op;
    logic [2:0]    dest;
    logic [TW-1:0] label;
    logic [TW-1:0] qj;
    logic [TW-1:0] qk;
    logic [DW-1:0] vj;
    logic [DW-1:0] vk;
    int            seq;
  } ment_t;

  ment_t m [2];
  bit    m_busy;
  int    m_xi;
  bit    m_err;
  int    seq_ctr;

  function automatic bit is_ready(input ment_t e);
    return e.used && !e.exec && (e.qj == 0) && (e.qk == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i] = '{default: 0};
    end
    m_busy = 0;
    m_xi = 0;
    m_err = 0;
    seq_ctr = 0;
  endtask

  task automatic model_step();
    ment_t o [2];
    bit ob, room, legal, hit;
    int k;
    o = m;
    ob = m_busy;
    room = !o[0].used || !o[1].used;
    legal = (iss_op < 3'd2);
    hit = cdb_valid && (cdb_label != 0);
    m_err = iss_valid && room && !legal;
    for (int i = 0; i < 2; i++) begin
      if (o[i].used && !o[i].exec && hit) begin
        if (o[i].qj == cdb_label) begin m[i].vj = cdb_data; m[i].qj = 0; end
        if (o[i].qk == cdb_label) begin m[i].vk = cdb_data; m[i].qk = 0; end
      end
    end
    if (!ob) begin
      k = -1;
      for (int i = 0; i < 2; i++) begin
        if (is_ready(o[i])) begin
`ifdef ADDSUB_RS_OLDEST_FIRST_EN
          if (k < 0 || o[i].seq < o[k].seq) k = i;
`else
          if (k < 0) k = i;
`endif
        end
      end
      if (k >= 0) begin
        m[k].exec = 1;
        m_busy = 1;
        m_xi = k;
      end
    end else if (fu_done) begin
      m[m_xi].used = 0;
      m[m_xi].exec = 0;
      m_busy = 0;
    end
    if (iss_valid && room && legal) begin
      k = o[0].used ? 1 : 0;
      m[k].used = 1;
      m[k].exec = 0;
      m[k].op = iss_op;
      m[k].dest = iss_dest;
      m[k].label = iss_label;
      m[k].vj = iss_vj;
      m[k].qj = iss_qj;
      m[k].vk = iss_vk;
      m[k].qk = iss_qk;
      if (hit && iss_qj == cdb_label) begin m[k].vj = cdb_data; m[k].qj = 0; end
      if (hit && iss_qk == cdb_label) begin m[k].vk = cdb_data; m[k].qk = 0; end
      m[k].seq = seq_ctr;
      seq_ctr++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string ctx);
    int cnt;
    cnt = int'(m[0].used) + int'(m[1].used);
    chk({ctx, " iss_ready"}, iss_ready, (!m[0].used || !m[1].used));
    chk({ctx, " iss_err"}, iss_err, m_err);
    chk({ctx, " busy_cnt"}, busy_cnt, cnt);
    chk({ctx, " fu_run"}, fu_run, m_busy);
    chk({ctx, " fu_op"}, fu_op, m_busy ? m[m_xi].op : 3'd0);
    chk({ctx, " fu_y"}, fu_y, m_busy ? m[m_xi].vj : 9'd0);
    chk({ctx, " fu_z"}, fu_z, m_busy ? m[m_xi].vk : 9'd0);
    chk({ctx, " fu_dest"}, fu_dest, m_busy ? m[m_xi].dest : 3'd0);
    chk({ctx, " fu_label"}, fu_label, m_busy ? m[m_xi].label : 3'd0);
  endtask

  task automatic tick(input string ctx);
    @(posedge clk);
    model_step();
    #1;
    check_model(ctx);
  endtask

  task automatic drive_idle();
    iss_valid = 0; iss_op = 0; iss_dest = 0; iss_label = 0;
    iss_vj = 0; iss_vk = 0; iss_qj = 0; iss_qk = 0;
    cdb_valid = 0; cdb_label = 0; cdb_data = 0; fu_done = 0;
  endtask

  typedef struct {
    int iv, op, dest, lab, vj, vk, qj, qk, cv, cl, cd, dn;
    int run, fop, y, z, fd, fl, rdy, err, cnt;
  } vec_t;

  function automatic vec_t mk(input int iv, op, dest, lab, vj, vk, qj, qk, cv, cl, cd, dn,
                              input int run, fop, y, z, fd, fl, rdy, err, cnt);
    vec_t r;
    r.iv = iv; r.op = op; r.dest = dest; r.lab = lab; r.vj = vj; r.vk = vk;
    r.qj = qj; r.qk = qk; r.cv = cv; r.cl = cl; r.cd = cd; r.dn = dn;
    r.run = run; r.fop = fop; r.y = y; r.z = z; r.fd = fd; r.fl = fl;
    r.rdy = rdy; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl [34];

  initial begin
    // iss: iv op dest lab vj vk qj qk | cdb: v l d | done | run op y z dest lab | rdy err cnt
    tbl[0]  = mk(1, 0, 3, 2, 5, 7, 0, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  1, 0, 5, 7, 3, 2,  1, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  1, 0, 5, 7, 3, 2,  1, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 0);
    tbl[4]  = mk(1, 1, 1, 5, 0, 9, 4, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 4, 20,  0,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  1, 1, 20, 9, 1, 5, 1, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 0);
    tbl[9]  = mk(1, 0, 2, 7, 1, 0, 0, 6,  1, 6, 511, 0,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  1, 0, 1, 511, 2, 7, 1, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 0);
    tbl[12] = mk(1, 0, 4, 1, 3, 4, 0, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[13] = mk(1, 1, 5, 3, 10, 2, 0, 0, 0, 0, 0,   0,  1, 0, 3, 4, 4, 1,  0, 0, 2);
    tbl[14] = mk(1, 0, 6, 6, 9, 9, 0, 0,  0, 0, 0,   0,  1, 0, 3, 4, 4, 1,  0, 0, 2);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  1, 1, 10, 2, 5, 3, 1, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 0);
    tbl[18] = mk(1, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  1, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  1, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 0);
    tbl[21] = mk(1, 0, 0, 4, 0, 1, 2, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[22] = mk(1, 1, 7, 5, 8, 0, 0, 2,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  0, 0, 2);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 100, 0,  0, 0, 0, 0, 0, 0,  0, 0, 2);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  1, 0, 100, 1, 0, 4, 0, 0, 2);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  1, 1, 8, 100, 7, 5, 1, 0, 1);
    tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 0);
    tbl[28] = mk(1, 0, 1, 1, 0, 2, 3, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[29] = mk(1, 0, 2, 2, 6, 6, 0, 0,  0, 0, 0,   0,  0, 0, 0, 0, 0, 0,  0, 0, 2);
    tbl[30] = mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 4,   0,  1, 0, 6, 6, 2, 2,  0, 0, 2);
    tbl[31] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 1);
    tbl[32] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0,  1, 0, 4, 2, 1, 1,  1, 0, 1);
    tbl[33] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   1,  0, 0, 0, 0, 0, 0,  1, 0, 0);

    drive_idle();
    reset_n = 0;
    model_reset();
    #12;
    chk("reset iss_ready", iss_ready, 1);
    chk("reset fu_run", fu_run, 0);
    chk("reset busy_cnt", busy_cnt, 0);
    chk("reset iss_err", iss_err, 0);
    chk("reset fu_y", fu_y, 0);
    reset_n = 1;

    for (int r = 0; r < 34; r++) begin
      iss_valid = 1'(tbl[r].iv);  iss_op = 3'(tbl[r].op);     iss_dest = 3'(tbl[r].dest);
      iss_label = TW'(tbl[r].lab); iss_vj = DW'(tbl[r].vj);   iss_vk = DW'(tbl[r].vk);
      iss_qj = TW'(tbl[r].qj);     iss_qk = TW'(tbl[r].qk);   cdb_valid = 1'(tbl[r].cv);
      cdb_label = TW'(tbl[r].cl);  cdb_data = DW'(tbl[r].cd); fu_done = 1'(tbl[r].dn);
      tick($sformatf("row%0d model", r));
      chk($sformatf("row%0d fu_run", r), fu_run, tbl[r].run);
      chk($sformatf("row%0d fu_op", r), fu_op, tbl[r].fop);
      chk($sformatf("row%0d fu_y", r), fu_y, tbl[r].y);
      chk($sformatf("row%0d fu_z", r), fu_z, tbl[r].z);
      chk($sformatf("row%0d fu_dest", r), fu_dest, tbl[r].fd);
      chk($sformatf("row%0d fu_label", r), fu_label, tbl[r].fl);
      chk($sformatf("row%0d iss_ready", r), iss_ready, tbl[r].rdy);
      chk($sformatf("row%0d iss_err", r), iss_err, tbl[r].err);
      chk($sformatf("row%0d busy_cnt", r), busy_cnt, tbl[r].cnt);
    end

    // Reset while the unit is busy; a later fu_done must be ignored.
    drive_idle();
    iss_valid = 1; iss_op = 3'b001; iss_dest = 3'd6; iss_label = 3'd4;
    iss_vj = 9'd40; iss_vk = 9'd2;
    tick("rst issue");
    drive_idle();
    tick("rst dispatch");
    chk("rst pre fu_run", fu_run, 1);
    chk("rst pre fu_y", fu_y, 40);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    chk("rst fu_run", fu_run, 0);
    chk("rst busy_cnt", busy_cnt, 0);
    chk("rst iss_ready", iss_ready, 1);
    check_model("rst asserted");
    #2;
    reset_n = 1;
    fu_done = 1;
    tick("rst late done");
    fu_done = 0;
    tick("rst after");
    chk("rst after fu_run", fu_run, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_op = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      iss_dest = 3'($urandom);
      iss_label = TW'($urandom);
      iss_vj = DW'($urandom);
      iss_vk = DW'($urandom);
      iss_qj = ($urandom_range(0, 1) == 1) ? TW'($urandom) : '0;
      iss_qk = ($urandom_range(0, 1) == 1) ? TW'($urandom) : '0;
      cdb_valid = ($urandom_range(0, 2) == 0);
      cdb_label = TW'($urandom);
      cdb_data = DW'($urandom);
      fu_done = ($urandom_range(0, 2) == 0);
      tick($sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
